time_split: RTL and testbench

- Sequencer that turns an elapsed-seconds count into seconds, minutes and hours using an external unsigned iterative divider.
- Issues divide-by-60 twice (divide-by-24 a third time with the optional feature) over the divider's enable/operand interface, and captures quotient/remainder on each divider done pulse.
- Sits between the seconds counter (upstream) and the display/BCD stage (downstream); the divider is instantiated alongside it as a peer.

---
 rtl/time_split_pkg.sv | 23 ++
 rtl/time_split.sv | 200 ++++++++++++++++++++
 tb/tb_time_split.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/time_split_pkg.sv
// Shared types and constants for the seconds-to-h:m:s sequencer.
// Day splitting is enabled with TIME_SPLIT_DAYS_EN.
package time_split_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_S,
    WAIT_S,
    ISSUE_M,
    WAIT_M,
`ifdef TIME_SPLIT_DAYS_EN
    ISSUE_H,
    WAIT_H,
`endif
    FINISH
  } state_e;

  localparam int SECS_PER_MIN   = 60;
  localparam int MINS_PER_HOUR  = 60;
  localparam int HOURS_PER_DAY  = 24;
  localparam int TIMEOUT_MARGIN = 4;

endpackage

// File: rtl/time_split.sv
// Splits elapsed seconds into h:m:s through an external iterative divider.
// Define TIME_SPLIT_DAYS_EN to add a days output and a third division.
module time_split
  import time_split_pkg::*;
#(
  parameter int WIDTH   = 17,
  parameter int TIMEOUT = WIDTH + TIMEOUT_MARGIN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] total_secs,
  output logic             busy,
  output logic             done,
  output logic             valid,
  output logic             err,
  output logic [5:0]       secs,
  output logic [5:0]       mins,
`ifdef TIME_SPLIT_DAYS_EN
  output logic [WIDTH-1:0] days,
`endif
  output logic [WIDTH-1:0] hours,
  output logic             div_enable,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  input  logic             div_done,
  input  logic             div_valid,
  input  logic             div_dbz,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic [WIDTH-1:0] div_rem
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [5:0]       secs_q, secs_d;
  logic [5:0]       mins_q, mins_d;
  logic [WIDTH-1:0] hours_q, hours_d;
  logic [WIDTH-1:0] days_q, days_d;
  logic             en_q, en_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WDW-1:0]   wd_q, wd_d;

  logic ok;
  logic wait_st;
  logic fail;
  logic fin;

  assign ok = div_valid & ~div_dbz;

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    err_d   = err_q;
    secs_d  = secs_q;
    mins_d  = mins_q;
    hours_d = hours_q;
    days_d  = days_q;
    en_d    = 1'b0;
    a_d     = a_q;
    b_d     = b_q;
    wd_d    = wd_q;
    wait_st = 1'b0;
    fail    = 1'b0;
    fin     = 1'b0;
    unique case (state_q)
      IDLE, FINISH: begin
        state_d = IDLE;
        if (start) begin
          state_d = ISSUE_S;
          busy_d  = 1'b1;
          valid_d = 1'b0;
          err_d   = 1'b0;
          en_d    = 1'b1;
          a_d     = total_secs;
          b_d     = WIDTH'(SECS_PER_MIN);
        end
      end
      ISSUE_S: begin
        state_d = WAIT_S;
        wd_d    = '0;
      end
      WAIT_S: begin
        wait_st = 1'b1;
        if (div_done && ok) begin
          secs_d  = div_rem[5:0];
          state_d = ISSUE_M;
          en_d    = 1'b1;
          a_d     = div_quotient;
          b_d     = WIDTH'(MINS_PER_HOUR);
        end
      end
      ISSUE_M: begin
        state_d = WAIT_M;
        wd_d    = '0;
      end
      WAIT_M: begin
        wait_st = 1'b1;
        if (div_done && ok) begin
          mins_d = div_rem[5:0];
`ifdef TIME_SPLIT_DAYS_EN
          state_d = ISSUE_H;
          en_d    = 1'b1;
          a_d     = div_quotient;
          b_d     = WIDTH'(HOURS_PER_DAY);
`else
          hours_d = div_quotient;
          fin     = 1'b1;
`endif
        end
      end
`ifdef TIME_SPLIT_DAYS_EN
      ISSUE_H: begin
        state_d = WAIT_H;
        wd_d    = '0;
      end
      WAIT_H: begin
        wait_st = 1'b1;
        if (div_done && ok) begin
          hours_d = div_rem;
          days_d  = div_quotient;
          fin     = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    // A done pulse wins over a watchdog expiry in the same cycle
    if (wait_st) begin
      if (div_done) fail = ~ok;
      else if (wd_q == WDW'(TIMEOUT)) fail = 1'b1;
      else wd_d = wd_q + 1'b1;
    end
    if (fail || fin) begin
      state_d = FINISH;
      done_d  = 1'b1;
      busy_d  = 1'b0;
      valid_d = fin;
      err_d   = fail;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      secs_q  <= '0;
      mins_q  <= '0;
      hours_q <= '0;
      days_q  <= '0;
      en_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      secs_q  <= secs_d;
      mins_q  <= mins_d;
      hours_q <= hours_d;
      days_q  <= days_d;
      en_q    <= en_d;
      a_q     <= a_d;
      b_q     <= b_d;
      wd_q    <= wd_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign valid      = valid_q;
  assign err        = err_q;
  assign secs       = secs_q;
  assign mins       = mins_q;
  assign hours      = hours_q;
  assign div_enable = en_q;
  assign div_a      = a_q;
  assign div_b      = b_q;

`ifdef TIME_SPLIT_DAYS_EN
  assign days = days_q;
`else
  logic unused_sigs;
  assign unused_sigs = ^{div_rem[WIDTH-1:6], days_q};
`endif

endmodule

// File: tb/tb_time_split.sv
// Scoreboard bench for time_split with a behavioural iterative divider.
// Define TIME_SPLIT_DAYS_EN to exercise the days split.
module tb_time_split;

  localparam int W  = 17;
  localparam int TO = W + 4;
`ifdef TIME_SPLIT_DAYS_EN
  localparam int NST = 3;
`else
  localparam int NST = 2;
`endif
  localparam int LAT = NST * (W + 2);

  typedef struct {
    int secs;
    int mins;
    int hours;
    int days;
    bit err;
    int lat;
    int n_en;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] total_secs = '0;
  logic         busy, done, valid, err;
  logic [5:0]   secs, mins;
  logic [W-1:0] hours, days;
  logic         div_enable;
  logic [W-1:0] div_a, div_b;
  logic         div_done, div_valid, div_dbz;
  logic [W-1:0] div_quotient, div_rem;

  logic         md_done, md_valid, md_dbz;
  logic [W-1:0] md_q, md_r, la, lb;
  int           dcnt;
  bit           kill_done = 1'b0;
  bit           force_dbz = 1'b0;

  int   cyc = 0;
  int   en_cnt = 0;
  int   done_cnt = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb[$];

  time_split dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .total_secs   (total_secs),
    .busy         (busy),
    .done         (done),
    .valid        (valid),
    .err          (err),
    .secs         (secs),
    .mins         (mins),
`ifdef TIME_SPLIT_DAYS_EN
    .days         (days),
`endif
    .hours        (hours),
    .div_enable   (div_enable),
    .div_a        (div_a),
    .div_b        (div_b),
    .div_done     (div_done),
    .div_valid    (div_valid),
    .div_dbz      (div_dbz),
    .div_quotient (div_quotient),
    .div_rem      (div_rem)
  );

`ifndef TIME_SPLIT_DAYS_EN
  assign days = '0;
`endif

  always #5 clk = ~clk;

  // Iterative divider: loads on enable, done W cycles later
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dcnt <= 0;
      md_done <= 1'b0;
      md_valid <= 1'b0;
      md_dbz <= 1'b0;
      md_q <= '0;
      md_r <= '0;
      la <= '0;
      lb <= '0;
    end else begin
      md_done <= 1'b0;
      if (div_enable) begin
        dcnt <= W;
        la <= div_a;
        lb <= div_b;
      end else if (dcnt != 0) begin
        dcnt <= dcnt - 1;
        if (dcnt == 1) begin
          md_done <= 1'b1;
          if (lb == 0) begin
            md_valid <= 1'b0;
            md_dbz <= 1'b1;
            md_q <= '1;
            md_r <= la;
          end else begin
            md_valid <= 1'b1;
            md_dbz <= 1'b0;
            md_q <= la / lb;
            md_r <= la % lb;
          end
        end
      end
    end
  end

  assign div_done     = md_done & ~kill_done;
  assign div_valid    = md_valid;
  assign div_dbz      = md_dbz | force_dbz;
  assign div_quotient = md_q;
  assign div_rem      = md_r;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (div_enable) en_cnt <= en_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int t, input bit e_err,
                          input int lat, input int n_en);
    exp_t e;
`ifdef TIME_SPLIT_DAYS_EN
    e.days  = t / 86400;
    e.hours = (t / 3600) % 24;
`else
    e.days  = 0;
    e.hours = t / 3600;
`endif
    e.mins  = (t / 60) % 60;
    e.secs  = t % 60;
    e.err   = e_err;
    e.lat   = lat;
    e.n_en  = n_en;
    sb.push_back(e);
  endtask

  task automatic run(input int t, input int dup_at, input bit e_err,
                     input int lat, input int n_en);
    exp_t e;
    int   t0;
    bit   seen;
    push_exp(t, e_err, lat, n_en);
    en_cnt = 0;
    done_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    total_secs = W'(t);
    @(posedge clk);
    #1;
    t0 = cyc;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      start = (dup_at > 0) && (cyc - t0 == dup_at);
      if (start) total_secs = W'(t + 7);
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    e = sb.pop_front();
    chk("done_seen", longint'(seen), 1);
    if (seen) begin
      chk("latency", cyc - t0, e.lat);
      chk("err", longint'(err), longint'(e.err));
      chk("valid", longint'(valid), longint'(!e.err));
      chk("busy_end", longint'(busy), 0);
      if (!e.err) begin
        chk("secs", longint'(secs), e.secs);
        chk("mins", longint'(mins), e.mins);
        chk("hours", longint'(hours), e.hours);
`ifdef TIME_SPLIT_DAYS_EN
        chk("days", longint'(days), e.days);
`endif
      end
    end
    repeat (40) @(negedge clk);
    chk("done_pulses", done_cnt, 1);
    chk("enables", en_cnt, e.n_en);
    chk("valid_held", longint'(valid), longint'(!e.err));
  endtask

  initial begin
    #1;
    chk("rst_busy", longint'(busy), 0);
    chk("rst_flags", longint'({done, valid, err, div_enable}), 0);
    chk("rst_fields", longint'({secs, mins, hours}), 0);
    chk("rst_div_ab", longint'({div_a, div_b}), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run(3661, 0, 1'b0, LAT, NST);
    run(86399, 0, 1'b0, LAT, NST);
    run(0, 0, 1'b0, LAT, NST);
    run(3661, 5, 1'b0, LAT, NST);
    run(125999, 0, 1'b0, LAT, NST);
`ifdef TIME_SPLIT_DAYS_EN
    run(90061, 0, 1'b0, LAT, NST);
`endif

    kill_done = 1'b1;
    run(3661, 0, 1'b1, TO + 2, 1);
    kill_done = 1'b0;
    force_dbz = 1'b1;
    run(3661, 0, 1'b1, W + 2, 1);
    force_dbz = 1'b0;

    // Abort a conversion while the second division is in flight
    en_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    total_secs = W'(3661);
    @(negedge clk);
    start = 1'b0;
    repeat (25) @(negedge clk);
    chk("pre_rst_enables", en_cnt, 2);
    chk("pre_rst_busy", longint'(busy), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", longint'(busy), 0);
    chk("mid_rst_flags", longint'({done, valid, err, div_enable}), 0);
    chk("mid_rst_secs", longint'(secs), 0);
    chk("mid_rst_fields", longint'({mins, hours}), 0);
    chk("mid_rst_div_ab", longint'({div_a, div_b}), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    run(59, 0, 1'b0, LAT, NST);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
